// File: rtl/avalon_if.sv
// Avalon-MM bundle: one host-side and one agent-side view of the same wires.
// A command beat transfers on a rising edge where read|write is high and waitrequest is low;
// readdatavalid qualifies readdata for exactly one cycle and cannot be back-pressured.
interface avalon_if #(
    parameter int ADDR_W       = 32,
    parameter int BURSTCOUNT_W = 4
);
    logic [ADDR_W-1:0]       address;
    logic                    read;
    logic                    write;
    logic [31:0]             writedata;
    logic [3:0]              byteenable;
    logic [BURSTCOUNT_W-1:0] burstcount;
    logic [31:0]             readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport host (
        output address, read, write, writedata, byteenable, burstcount,
        input  readdata, readdatavalid, waitrequest
    );

    modport agent (
        input  address, read, write, writedata, byteenable, burstcount,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_arbiter.sv
// Two-host round-robin arbiter in front of one Avalon-MM agent. A grant is held for a whole
// write burst or a whole read burst including every returned word.
module avalon_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int BURSTCOUNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    avalon_if.agent    avalon_h0,
    avalon_if.agent    avalon_h1,
    avalon_if.host     avalon_m,
    output logic [2:0] dbg_state,
    output logic       dbg_grant
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        WR      = 3'd2,
        RD_CMD  = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    localparam logic [BURSTCOUNT_W:0]   LEN_ONE = {{BURSTCOUNT_W{1'b0}}, 1'b1};
    localparam logic [BURSTCOUNT_W-1:0] BC_ONE  = {{(BURSTCOUNT_W-1){1'b0}}, 1'b1};

    state_t                state, state_n;
    logic                  grant, grant_n;
    logic                  last, last_n;
    logic [BURSTCOUNT_W:0] beat, beat_n;
    logic [BURSTCOUNT_W:0] len, len_n;
    logic [BURSTCOUNT_W:0] beat_inc;

    logic                    req0, req1;
    logic                    g_read, g_write;
    logic [ADDR_W-1:0]       g_address;
    logic [31:0]             g_writedata;
    logic [3:0]              g_byteenable;
    logic [BURSTCOUNT_W-1:0] g_burstcount;

    logic                    m_read, m_write;
    logic [ADDR_W-1:0]       m_address;
    logic [31:0]             m_writedata;
    logic [3:0]              m_byteenable;
    logic [BURSTCOUNT_W-1:0] m_burstcount;

    logic        fwd_wait;
    logic        fwd_rdv;
    logic [31:0] fwd_rdata;

    assign req0 = avalon_h0.read | avalon_h0.write;
    assign req1 = avalon_h1.read | avalon_h1.write;

    assign g_read       = grant ? avalon_h1.read       : avalon_h0.read;
    assign g_write      = grant ? avalon_h1.write      : avalon_h0.write;
    assign g_address    = grant ? avalon_h1.address    : avalon_h0.address;
    assign g_writedata  = grant ? avalon_h1.writedata  : avalon_h0.writedata;
    assign g_byteenable = grant ? avalon_h1.byteenable : avalon_h0.byteenable;
    assign g_burstcount = grant ? avalon_h1.burstcount : avalon_h0.burstcount;

    // One bit wider than burstcount so the maximum burst length compares without wrapping.
    assign beat_inc = beat + LEN_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
            beat  <= '0;
            len   <= LEN_ONE;
        end else begin
            state <= state_n;
            grant <= grant_n;
            last  <= last_n;
            beat  <= beat_n;
            len   <= len_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_n       = last;
        beat_n       = beat;
        len_n        = len;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_address    = '0;
        m_writedata  = '0;
        m_byteenable = '0;
        m_burstcount = BC_ONE;
        fwd_wait     = 1'b1;
        fwd_rdv      = 1'b0;
        fwd_rdata    = '0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_n = (req0 && req1) ? !last : req1;
                    state_n = ARB;
                end
            end
            ARB: begin
                // A zero burstcount still moves one beat.
                len_n   = (g_burstcount == '0) ? LEN_ONE : {1'b0, g_burstcount};
                beat_n  = '0;
                last_n  = grant;
                state_n = g_write ? WR : RD_CMD;
            end
            WR: begin
                m_write      = g_write;
                m_address    = g_address;
                m_writedata  = g_writedata;
                m_byteenable = g_byteenable;
                m_burstcount = g_burstcount;
                fwd_wait     = avalon_m.waitrequest;
                if (g_write && !avalon_m.waitrequest) begin
                    beat_n = beat_inc;
                    if (beat_inc == len) state_n = IDLE;
                end
            end
            RD_CMD: begin
                m_read       = g_read;
                m_address    = g_address;
                m_burstcount = g_burstcount;
                fwd_wait     = avalon_m.waitrequest;
                if (g_read && !avalon_m.waitrequest) state_n = RD_DATA;
            end
            RD_DATA: begin
                fwd_rdv   = avalon_m.readdatavalid;
                fwd_rdata = avalon_m.readdata;
                if (avalon_m.readdatavalid) begin
                    beat_n = beat_inc;
                    if (beat_inc == len) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign avalon_m.read       = m_read;
    assign avalon_m.write      = m_write;
    assign avalon_m.address    = m_address;
    assign avalon_m.writedata  = m_writedata;
    assign avalon_m.byteenable = m_byteenable;
    assign avalon_m.burstcount = m_burstcount;

    // The losing host always sees a stall and never sees read data.
    assign avalon_h0.waitrequest   = grant ? 1'b1  : fwd_wait;
    assign avalon_h0.readdatavalid = grant ? 1'b0  : fwd_rdv;
    assign avalon_h0.readdata      = grant ? '0    : fwd_rdata;
    assign avalon_h1.waitrequest   = grant ? fwd_wait  : 1'b1;
    assign avalon_h1.readdatavalid = grant ? fwd_rdv   : 1'b0;
    assign avalon_h1.readdata      = grant ? fwd_rdata : '0;

    assign dbg_state = state;
    assign dbg_grant = grant;

endmodule
